// File: rtl/tpu_pkg.sv
// Shared types and size helpers for the matrix-unit sequencer.
package tpu_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

   // Operand beats per run: A and B, one element per beat.
   function automatic int load_len_f(input int n);
      return 2 * n * n;
   endfunction

   // Feed cycles needed for the last skewed element to reach the far corner.
   function automatic int t_len_f(input int n);
      return 3 * n - 2;
   endfunction

   // Host bytes per accumulator.
   function automatic int bytes_f(input int acc_w, input int bus_w);
      return acc_w / bus_w;
   endfunction

   // Select width; the extra code point N encodes a bubble.
   function automatic int sel_w_f(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/skew_sel_gen.sv
// Maps the compute cycle counter onto diagonally skewed element selects.
// Lane i sees element t-i while that index is in range, otherwise the bubble
// code N. The same block serves A rows and B columns.
module skew_sel_gen
   import tpu_pkg::*;
#(
   parameter int N  = 2,
   parameter int SW = sel_w_f(N),
   parameter int TW = 3
) (
   input  logic          en,
   input  logic [TW-1:0] t,
   output logic [N*SW-1:0] sel
);

   logic [N-1:0][SW-1:0] lane_sel;

   for (genvar i = 0; i < N; i++) begin : g_lane
      int d;
      // Lane i lags lane 0 by i cycles; outside the window it feeds a bubble.
      always_comb begin
         d = int'(t) - i;
         lane_sel[i] = SW'(N);
         if (en && (d >= 0) && (d < N))
            lane_sel[i] = SW'(d);
      end
   end

   assign sel = lane_sel;

endmodule

// File: rtl/mmu_sequencer.sv
// Sequencer for an NxN output-stationary systolic unit: byte-stream operand
// load, skewed feed control, result snapshot and byte-wise drain. A new
// operand set may load while the previous results drain.
module mmu_sequencer
   import tpu_pkg::*;
#(
   parameter int N      = 2,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int BUS_W  = 8,
   localparam int SW    = sel_w_f(N),
   localparam int AW    = $clog2(2 * N * N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [BUS_W-1:0]       in_data,
   input  logic                   transpose,
   input  logic                   accumulate,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_waddr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   array_clear,
   output logic                   array_en,
   output logic [N*SW-1:0]        a_sel,
   output logic [N*SW-1:0]        b_sel,
   output logic                   transpose_q,
   input  logic [N*N*ACC_W-1:0]   result_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BUS_W-1:0]       out_data,
   output logic                   busy,
   output logic                   done
);

   localparam int LOAD_LEN = load_len_f(N);
   localparam int T        = t_len_f(N);
   localparam int BYTES    = bytes_f(ACC_W, BUS_W);
   localparam int NB       = N * N * BYTES;
   localparam int LW       = $clog2(LOAD_LEN + 1);
   localparam int TW       = $clog2(T + 1);
   localparam int BW       = $clog2(NB);

   state_t                   state, state_nxt;
   logic [LW-1:0]            load_cnt;
   logic [TW-1:0]            t_cnt;
   logic [BW-1:0]            byte_idx;
   logic [N*N*ACC_W-1:0]     snapshot;
   logic                     load_pending, accumulate_q;
   logic                     accept, load_last, byte_fire, last_byte, entering;
   logic [NB-1:0][BUS_W-1:0] snap_bytes;

   assign accept    = in_valid && in_ready;
   assign load_last = accept && (load_cnt == LW'(LOAD_LEN - 1));
   assign byte_fire = out_valid && out_ready;
   assign last_byte = byte_fire && (byte_idx == BW'(NB - 1));
   assign entering  = (state_nxt == COMPUTE) && (state != COMPUTE);

   assign mem_we    = accept;
   assign mem_waddr = load_cnt[AW-1:0];
   assign mem_wdata = in_data;
   assign done      = last_byte;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state; a beat landing on the final drain cycle still counts.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    if (load_last) state_nxt = COMPUTE;
         COMPUTE: if (t_cnt == TW'(T)) state_nxt = DRAIN;
         DRAIN:
            if (last_byte) begin
               if (load_pending || load_last)        state_nxt = COMPUTE;
               else if ((load_cnt != '0) || accept)  state_nxt = LOAD;
               else                                  state_nxt = IDLE;
            end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and array control decoded from state.
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      array_en    = 1'b0;
      array_clear = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE, LOAD: in_ready = 1'b1;
         COMPUTE: begin
            array_en    = (t_cnt != TW'(T));
            array_clear = (t_cnt == '0) && !accumulate_q;
         end
         DRAIN: begin
            in_ready  = (load_cnt < LW'(LOAD_LEN));
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Counters, mode latches and the result snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_cnt     <= '0;
         load_pending <= 1'b0;
         t_cnt        <= '0;
         byte_idx     <= '0;
         snapshot     <= '0;
         transpose_q  <= 1'b0;
         accumulate_q <= 1'b0;
      end else begin
         if (entering)    load_cnt <= '0;
         else if (accept) load_cnt <= load_cnt + LW'(1);
         load_pending <= (state == DRAIN) && (state_nxt == DRAIN) && (load_pending || load_last);
         t_cnt <= ((state == COMPUTE) && (t_cnt != TW'(T))) ? t_cnt + TW'(1) : '0;
         if (byte_fire) byte_idx <= last_byte ? '0 : byte_idx + BW'(1);
         if (entering) begin
            transpose_q  <= transpose;
            accumulate_q <= accumulate;
         end
         if ((state == COMPUTE) && (t_cnt == TW'(T))) snapshot <= result_in;
      end
   end

   // Byte view of the snapshot: element-major, MSB byte first.
   for (genvar b = 0; b < NB; b++) begin : g_byte
      assign snap_bytes[b] = snapshot[(b / BYTES) * ACC_W + (BYTES - 1 - b % BYTES) * BUS_W +: BUS_W];
   end

   assign out_data = out_valid ? snap_bytes[byte_idx] : '0;

   skew_sel_gen #(.N(N), .SW(SW), .TW(TW)) u_a_sel (.en(array_en), .t(t_cnt), .sel(a_sel));
   skew_sel_gen #(.N(N), .SW(SW), .TW(TW)) u_b_sel (.en(array_en), .t(t_cnt), .sel(b_sel));

endmodule

// File: tb/tb_mmu_sequencer.sv
// Directed bench for mmu_sequencer at N=2 with a behavioural 2x2 systolic array.
module tb_mmu_sequencer;

   logic        clk = 1'b0;
   logic        rst, in_valid, transpose, accumulate, out_ready;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, array_clear, array_en, transpose_q;
   logic        out_valid, busy, done;
   logic [2:0]  mem_waddr;
   logic [7:0]  mem_wdata, out_data;
   logic [3:0]  a_sel, b_sel;
   logic [63:0] result_in;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int clr_cnt = 0;

   always #5 clk = ~clk;

   mmu_sequencer #(.N(2), .DATA_W(8), .ACC_W(16), .BUS_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .transpose(transpose), .accumulate(accumulate), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .array_clear(array_clear), .array_en(array_en), .a_sel(a_sel),
      .b_sel(b_sel), .transpose_q(transpose_q), .result_in(result_in), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
   );

   // ---- behavioural operand memory and output-stationary array ----
   logic [7:0]  mem [8];
   logic [7:0]  ar [2][2], br [2][2], a_in [2][2], b_in [2][2];
   logic [15:0] acc [2][2];

   function automatic logic [7:0] a_val(input int i, input logic [1:0] k);
      logic [2:0] ix;
      if (k >= 2'd2) return 8'd0;
      ix = 3'(i * 2 + int'(k));
      return mem[ix];
   endfunction

   function automatic logic [7:0] b_val(input int j, input logic [1:0] k, input logic tq);
      logic [2:0] ix;
      if (k >= 2'd2) return 8'd0;
      ix = tq ? 3'(4 + j * 2 + int'(k)) : 3'(4 + int'(k) * 2 + j);
      return mem[ix];
   endfunction

   always_comb begin
      a_in[0][0] = a_val(0, a_sel[1:0]);
      a_in[1][0] = a_val(1, a_sel[3:2]);
      a_in[0][1] = ar[0][0];
      a_in[1][1] = ar[1][0];
      b_in[0][0] = b_val(0, b_sel[1:0], transpose_q);
      b_in[0][1] = b_val(1, b_sel[3:2], transpose_q);
      b_in[1][0] = br[0][0];
      b_in[1][1] = br[0][1];
   end

   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (done) done_cnt <= done_cnt + 1;
      if (array_clear && !rst) clr_cnt <= clr_cnt + 1;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            if (rst) begin
               ar[i][j]  <= 8'd0;
               br[i][j]  <= 8'd0;
               acc[i][j] <= 16'd0;
            end else if (array_en) begin
               acc[i][j] <= (array_clear ? 16'd0 : acc[i][j]) + {8'd0, a_in[i][j]} * {8'd0, b_in[i][j]};
               ar[i][j]  <= a_in[i][j];
               br[i][j]  <= b_in[i][j];
            end
   end

   assign result_in = {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};

   // ---- vector tables ----
   typedef struct {
      logic [3:0] a_sel;
      logic [3:0] b_sel;
      logic       clr;
      logic       en;
      logic       poke_valid;
   } trace_t;

   trace_t     tr [5];
   logic [7:0] set1 [8];
   logic [7:0] c1 [8], c2 [8], c1t [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_in_ready"},    64'(in_ready),    64'(1));
      chk({tag, "_busy"},        64'(busy),        64'(0));
      chk({tag, "_out_valid"},   64'(out_valid),   64'(0));
      chk({tag, "_out_data"},    64'(out_data),    64'(0));
      chk({tag, "_done"},        64'(done),        64'(0));
      chk({tag, "_mem_we"},      64'(mem_we),      64'(0));
      chk({tag, "_array_en"},    64'(array_en),    64'(0));
      chk({tag, "_array_clear"}, 64'(array_clear), 64'(0));
      chk({tag, "_a_sel"},       64'(a_sel),       64'(4'b1010));
      chk({tag, "_b_sel"},       64'(b_sel),       64'(4'b1010));
      chk({tag, "_transpose_q"}, 64'(transpose_q), 64'(0));
   endtask

   // Called at a negedge; returns at the negedge after the last beat is taken.
   task automatic load_set(input logic [7:0] d [8]);
      int i = 0;
      int c = 0;
      while (i < 8 && c < 100) begin
         if (in_ready) begin
            in_valid = 1'b1;
            in_data  = d[i];
            #1;
            chk("load_mem_we",    64'(mem_we),    64'(1));
            chk("load_mem_waddr", 64'(mem_waddr), 64'(i));
            chk("load_mem_wdata", 64'(mem_wdata), 64'(d[i]));
            i++;
         end else begin
            in_valid = 1'b0;
         end
         c++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'd0;
      chk("load_beats", 64'(i), 64'(8));
      chk("in_ready_after_load", 64'(in_ready), 64'(0));
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!out_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("reach_drain", 64'(out_valid), 64'(1));
   endtask

   // Drains 8 bytes with out_ready following pat (bit c%4 on cycle c).
   task automatic drain(input logic [7:0] exp [8], input logic [3:0] pat);
      int idx = 0;
      int c = 0;
      while (idx < 8 && c < 100) begin
         out_ready = pat[c % 4];
         #1;
         chk("drain_valid", 64'(out_valid), 64'(1));
         chk("drain_data",  64'(out_data),  64'(exp[idx]));
         chk("drain_done",  64'(done),      64'(out_ready && idx == 7));
         if (out_ready) idx++;
         c++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("drain_handshakes", 64'(idx), 64'(8));
   endtask

   initial begin
      int d0, k0;
      tr[0] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0};
      tr[1] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0};
      tr[2] = '{4'b0110, 4'b0110, 1'b0, 1'b1, 1'b1};
      tr[3] = '{4'b1010, 4'b1010, 1'b0, 1'b1, 1'b0};
      tr[4] = '{4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1};
      set1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      c1   = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
      c2   = '{8'h00, 8'h26, 8'h00, 8'h2C, 8'h00, 8'h56, 8'h00, 8'h64};
      c1t  = '{8'h00, 8'h11, 8'h00, 8'h17, 8'h00, 8'h27, 8'h00, 8'h35};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
      transpose = 1'b0; accumulate = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      @(negedge clk);

      // Run 1: plain product, feed trace, latency, and no write while computing.
      d0 = done_cnt; k0 = clr_cnt;
      load_set(set1);
      for (int r = 0; r < 5; r++) begin
         in_valid = tr[r].poke_valid;
         #1;
         chk("trace_a_sel", 64'(a_sel),       64'(tr[r].a_sel));
         chk("trace_b_sel", 64'(b_sel),       64'(tr[r].b_sel));
         chk("trace_clear", 64'(array_clear), 64'(tr[r].clr));
         chk("trace_en",    64'(array_en),    64'(tr[r].en));
         chk("trace_busy",  64'(busy),        64'(1));
         chk("trace_no_we", 64'(mem_we),      64'(0));
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("latency_out_valid", 64'(out_valid), 64'(1));
      drain(c1, 4'b1111);
      chk("run1_busy_after", 64'(busy), 64'(0));
      chk("run1_done_pulses", 64'(done_cnt - d0), 64'(1));
      chk("run1_clears", 64'(clr_cnt - k0), 64'(1));

      // Run 2: accumulate on top of run 1, no clear.
      accumulate = 1'b1;
      k0 = clr_cnt;
      load_set(set1);
      accumulate = 1'b0;
      wait_valid();
      drain(c2, 4'b1111);
      chk("acc_clears", 64'(clr_cnt - k0), 64'(0));

      // Run 3: stalled drain overlapped by a full reload, then straight into compute.
      load_set(set1);
      wait_valid();
      transpose = 1'b1;
      d0 = done_cnt;
      fork
         load_set(set1);
         drain(c1, 4'b1001);
      join
      chk("overlap_busy",        64'(busy),        64'(1));
      chk("overlap_compute_en",  64'(array_en),    64'(1));
      chk("overlap_clear",       64'(array_clear), 64'(1));
      chk("overlap_out_valid",   64'(out_valid),   64'(0));
      chk("overlap_transpose_q", 64'(transpose_q), 64'(1));
      chk("overlap_done_pulses", 64'(done_cnt - d0), 64'(1));
      transpose = 1'b0;
      wait_valid();
      drain(c1t, 4'b1111);
      chk("run4_busy_after", 64'(busy), 64'(0));

      // Run 5: reset at compute t=1, then a clean reload.
      transpose = 1'b1;
      load_set(set1);
      @(negedge clk);
      chk("mid_pre_en", 64'(array_en), 64'(1));
      chk("mid_pre_transpose_q", 64'(transpose_q), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check_reset("mid");
      rst = 1'b0;
      transpose = 1'b0;
      @(negedge clk);
      load_set(set1);
      wait_valid();
      drain(c1, 4'b1111);
      chk("run5_busy_after", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
Parametrised sequencer for an NxN output-stationary systolic matrix unit. It accepts operands as a byte stream from the host and writes them into operand memory. It then drives the skewed feed selects and clear/enable controls of the array. Finally it snapshots the results and streams them back over a valid/ready byte interface. Loading of the next operand set may overlap the result drain. Sits between the host byte port, operand memory and the systolic array.

Parameters:
N, 2, array dimension (N>=2); operands are NxN matrices
DATA_W, 8, operand element width; equals BUS_W (one element per beat)
ACC_W, 16, accumulator/result width; must be a multiple of BUS_W
BUS_W, 8, host byte-stream width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  host operand beat valid
in_ready  out  1  sequencer can accept an operand beat
in_data  in  BUS_W  operand element
transpose  in  1  B-fetch transpose mode; sampled at COMPUTE entry
accumulate  in  1  skip array clear this run; sampled at COMPUTE entry
mem_we  out  1  operand memory write strobe (= in_valid && in_ready)
mem_waddr  out  clog2(2*N*N)  write address; 0..N*N-1 = A, N*N..2N*N-1 = B, row-major
mem_wdata  out  DATA_W  = in_data
array_clear  out  1  zero accumulators (first compute cycle only)
array_en  out  1  array advances this cycle
a_sel  out  N*SW  per-row A element index, SW = clog2(N+1); value N = bubble/zero
b_sel  out  N*SW  per-column B element index; value N = bubble/zero
transpose_q  out  1  latched transpose mode to the B mux
result_in  in  N*N*ACC_W  array accumulators, row-major, c[0][0] in LSBs
out_valid  out  1  result byte valid
out_ready  in  1  host accepts result byte
out_data  out  BUS_W  result byte; 0 when out_valid=0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last result byte is accepted

Behaviour:
- Reset (synchronous): state=IDLE; load/compute/drain counters=0; snapshot=0; load_pending=0. All outputs 0 except in_ready=1. a_sel/b_sel=N. Applies mid-operation with no partial writes or drains.
- LOAD_LEN = 2*N*N beats. T = 3N-2 feed cycles. BYTES = ACC_W/BUS_W.
- in_ready=1 in IDLE and LOAD, and in DRAIN while load_cnt<LOAD_LEN; 0 in COMPUTE.
- Each accepted beat writes mem_waddr=load_cnt, then load_cnt++. Writes are combinational strobes in the same cycle.
- IDLE: first accepted beat -> LOAD.
- LOAD: the beat with load_cnt=LOAD_LEN-1 accepted -> COMPUTE next cycle. load_cnt resets to 0.
- COMPUTE: cycle counter t=0..T (T+1 cycles). transpose and accumulate are latched on entry.
  - t<T: array_en=1; a_sel[i] = t-i if 0<=t-i<N, else N; b_sel[j] likewise with t-j.
  - array_clear=1 only at t=0, and only if accumulate_q=0.
  - t=T: settle cycle with array_en=0; result_in is captured into the snapshot at the end of this cycle -> DRAIN.
- DRAIN: bytes are emitted row-major by element, MSB byte first. out_valid=1, and out_data is held stable until out_ready.
  - The byte index advances only on out_valid&&out_ready.
  - On acceptance of the final byte: done=1 for that cycle. Next state: COMPUTE if load_cnt==LOAD_LEN (full set already loaded; reset load_cnt), else LOAD if load_cnt>0, else IDLE.
- A load completing in DRAIN sets load_pending (load_cnt saturates at LOAD_LEN; in_ready drops to 0).
- Overwriting operand memory during DRAIN is legal because the results are already snapshotted.
- in_valid while in_ready=0 is ignored with no write.
- Latency, N=2 with no stalls: last load beat at cycle k -> COMPUTE k+1..k+5 -> first out_valid at k+6.

Decomposition:
- tpu_pkg: state enum (IDLE, LOAD, COMPUTE, DRAIN); localparam functions for LOAD_LEN, T, BYTES and SW.
- Sub-module skew_sel_gen(N): maps t to the packed a_sel/b_sel vectors. It is reused for rows and columns.
- Drain byte-mux/snapshot stays in the top level.

Test Plan:
- N=2: A=[1,2,3,4], B=[5,6,7,8], array model, out_ready=1 -> bytes 00 13 00 16 00 2B 00 32. done pulses once; busy falls the cycle after.
- N=2: a_sel/b_sel trace for t=0..3 -> a_sel[0]:0,1,2,2 and a_sel[1]:2,0,1,2. array_clear only at t=0. Settle cycle has array_en=0.
- Repeat the first case with accumulate=1 -> 00 26 00 2C 00 56 00 64. No array_clear.
- out_ready toggling 1-0-0-1 during drain -> out_data held stable while stalled; byte order unchanged; exactly 8 handshakes.
- Full second load (8 beats) during drain -> in_ready=0 after the 8th beat. COMPUTE is entered the cycle after the final result byte without returning to IDLE.
- rst asserted at COMPUTE t=1 -> next cycle IDLE, all outputs at reset values. A fresh 8-beat load gives the correct result.
